// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, interrupt cause numbering, CSR op encodings, FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Channel 0 is the machine timer (cause 7); channel k>=1 maps to cause 15+k.
    localparam logic [4:0] CAUSE_MTI      = 5'd7;
    localparam logic [4:0] CAUSE_IRQ_BASE = 5'd15;

    // Only MIE (bit 3) and MPIE (bit 7) exist in mstatus.
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } trap_state_e;

    // The cause number doubles as the mip/mie bit position of a channel.
    function automatic logic [4:0] chan_cause(input int k);
        logic [4:0] c;
        if (k == 0) c = CAUSE_MTI;
        else        c = CAUSE_IRQ_BASE + 5'(k);
        return c;
    endfunction

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        logic [31:0] r;
        case (op)
            CSR_OP_WRITE: r = wdata;
            CSR_OP_SET:   r = old_val | wdata;
            CSR_OP_CLEAR: r = old_val & ~wdata;
            default:      r = old_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over pending-and-enabled interrupt channels.
// Lowest channel index wins; cause is the architectural cause number.
module irq_prio_enc
    import csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] pend,
    output logic               any,
    output logic [4:0]         cause
);

    // Scan from the top channel down so the lowest pending index is assigned last.
    always_comb begin
        any   = |pend;
        cause = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pend[k]) cause = chan_cause(k);
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file (mstatus/mie/mip/mtvec/mepc/mcause) and trap/mret
// redirect controller with NUM_IRQ level-sensitive interrupt channels.
// Optional feature macro: CSR_VECTORED_EN enables vectored mtvec mode.
//
// state | meaning
// RUN   | normal operation, traps/mret/CSR writes accepted
// FLUSH | one cycle after a trap or mret while the pipeline refills
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               instr_valid_de,
    input  logic [31:0]        pc_de,
    input  logic               csr_rf_rd,
    input  logic               csr_rf_wr,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    input  logic               mret,
    output logic [31:0]        csr_rdata,
    output logic               trap_taken,
    output logic [31:0]        trap_pc,
    output logic               mret_taken,
    output logic [31:0]        epc
);

`ifdef CSR_VECTORED_EN
    // bit 0 is the mode bit (1 = vectored); bit 1 stays 0.
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    trap_state_e state_q, state_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic [31:0]        chan_mask;
    logic [NUM_IRQ-1:0] pend;
    logic               pend_any;
    logic [4:0]         irq_cause;
    logic               in_run;
    logic               wr_en;
    logic [31:0]        csr_old;
    logic [31:0]        csr_new;
    logic [31:0]        mtvec_base;

    // Map channels onto their mip/mie bit positions and form the pending vector.
    always_comb begin
        chan_mask = '0;
        mip_d     = '0;
        pend      = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            chan_mask[chan_cause(k)] = 1'b1;
            mip_d[chan_cause(k)]     = irq[k];
            pend[k]                  = mip_q[chan_cause(k)] & mie_q[chan_cause(k)];
        end
    end

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .pend  (pend),
        .any   (pend_any),
        .cause (irq_cause)
    );

    // CSR read mux and redirect decisions.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        trap_taken = in_run & instr_valid_de & ~mret & mstatus_q[3] & pend_any;
        mret_taken = in_run & instr_valid_de & mret;
        wr_en      = csr_rf_wr & in_run & ~trap_taken;
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_q;
            CSR_MIE:     csr_old = mie_q;
            CSR_MIP:     csr_old = mip_q;
            CSR_MTVEC:   csr_old = mtvec_q;
            CSR_MEPC:    csr_old = mepc_q;
            CSR_MCAUSE:  csr_old = mcause_q;
            default:     csr_old = '0;
        endcase
        csr_new    = csr_apply(csr_op_e'(csr_op), csr_old, csr_wdata);
        csr_rdata  = (csr_rf_rd && in_run) ? csr_old : '0;
        epc        = mepc_q;
        mtvec_base = mtvec_q & 32'hFFFF_FFFC;
        trap_pc    = mtvec_base;
`ifdef CSR_VECTORED_EN
        if (mtvec_q[0]) trap_pc = mtvec_base + {25'd0, irq_cause, 2'b00};
`endif
    end

    // Next-state for the FSM and CSRs; a trap overrides the same-cycle CSR write.
    always_comb begin
        state_d   = state_q;
        mstatus_d = mstatus_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        case (state_q)
            ST_RUN:   if (trap_taken || mret_taken) state_d = ST_FLUSH;
            default:  state_d = ST_RUN;
        endcase
        if (trap_taken) begin
            mepc_d       = pc_de & 32'hFFFF_FFFC;
            mcause_d     = {1'b1, 26'd0, irq_cause};
            mstatus_d[7] = mstatus_q[3];
            mstatus_d[3] = 1'b0;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus_d = csr_new & MSTATUS_MASK;
                CSR_MIE:     mie_d     = csr_new & chan_mask;
                CSR_MTVEC:   mtvec_d   = csr_new & MTVEC_MASK;
                CSR_MEPC:    mepc_d    = csr_new & 32'hFFFF_FFFC;
                CSR_MCAUSE:  mcause_d  = csr_new;
                default:     ;
            endcase
        end
        // mret restores from the pre-instruction MPIE.
        if (mret_taken) begin
            mstatus_d[3] = mstatus_q[7];
            mstatus_d[7] = 1'b1;
        end
    end

    // State and CSR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            mstatus_q <= '0;
            mie_q     <= '0;
            mip_q     <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            state_q   <= state_d;
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mip_q     <= mip_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios with literal
// expectations, then randomized traffic against an architectural model.
module tb_csr_trap_unit;

    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq;
    logic               instr_valid_de;
    logic [31:0]        pc_de;
    logic               csr_rf_rd;
    logic               csr_rf_wr;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic               mret;
    logic [31:0]        csr_rdata;
    logic               trap_taken;
    logic [31:0]        trap_pc;
    logic               mret_taken;
    logic [31:0]        epc;

    csr_trap_unit #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .instr_valid_de (instr_valid_de),
        .pc_de          (pc_de),
        .csr_rf_rd      (csr_rf_rd),
        .csr_rf_wr      (csr_rf_wr),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .mret           (mret),
        .csr_rdata      (csr_rdata),
        .trap_taken     (trap_taken),
        .trap_pc        (trap_pc),
        .mret_taken     (mret_taken),
        .epc            (epc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural model state.
    logic        m_known = 1'b0;
    logic        m_flush;
    logic        m_mie_b, m_mpie;
    logic [31:0] m_mie, m_mip, m_mtvec, m_mepc, m_mcause;

    // Last observed DUT outputs, for literal checks in the directed part.
    logic        o_trap, o_mret;
    logic [31:0] o_rdata, o_tpc, o_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_bit(input int k);
        return (k == 0) ? 7 : 15 + k;
    endfunction

    function automatic logic [31:0] m_chmask();
        logic [31:0] m = '0;
        for (int k = 0; k < NUM_IRQ; k++) m[m_bit(k)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] v;
        case (a)
            12'h300: v = (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = m_mip;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cyc(input logic [NUM_IRQ-1:0] ir, input logic v, input logic [31:0] pc,
                       input logic rd_en, input logic w_en, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd, input logic mr,
                       input logic r);
        logic [31:0] pend, old_v, nv, base, e_tpc, e_rd, new_mip;
        logic        run, e_trap, e_mret, wr_ok, pre_mpie;
        int          cs;
        @(negedge clk);
        rst = r; irq = ir; instr_valid_de = v; pc_de = pc; csr_rf_rd = rd_en;
        csr_rf_wr = w_en; csr_op = op; csr_addr = a; csr_wdata = wd; mret = mr;
        #1;
        o_trap = trap_taken; o_mret = mret_taken; o_rdata = csr_rdata;
        o_tpc = trap_pc; o_epc = epc;

        run  = !m_flush;
        pend = m_mip & m_mie;
        cs   = 0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) if (pend[m_bit(k)]) cs = m_bit(k);
        e_trap = run && v && !mr && m_mie_b && (pend != 0);
        e_mret = run && v && mr;
        base   = m_mtvec & ~32'h3;
        e_tpc  = base;
`ifdef CSR_VECTORED_EN
        if (m_mtvec[0]) e_tpc = base + 32'(4 * cs);
`endif
        old_v = m_read(a);
        e_rd  = (rd_en && run) ? old_v : 32'h0;
        if (m_known) begin
            chk("trap_taken", 32'(o_trap), 32'(e_trap));
            chk("mret_taken", 32'(o_mret), 32'(e_mret));
            chk("csr_rdata", o_rdata, e_rd);
            chk("epc", o_epc, m_mepc);
            if (e_trap) chk("trap_pc", o_tpc, e_tpc);
        end

        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_flush = 1'b0; m_mie_b = 1'b0; m_mpie = 1'b0;
            m_mie = '0; m_mip = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
        end else if (m_known) begin
            new_mip = '0;
            for (int k = 0; k < NUM_IRQ; k++) new_mip[m_bit(k)] = ir[k];
            pre_mpie = m_mpie;
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = old_v | wd;
                2'b11:   nv = old_v & ~wd;
                default: nv = old_v;
            endcase
            wr_ok = w_en && run && !e_trap;
            if (e_trap) begin
                m_mepc   = pc & ~32'h3;
                m_mcause = 32'h8000_0000 | 32'(cs);
                m_mpie   = m_mie_b;
                m_mie_b  = 1'b0;
            end else if (wr_ok) begin
                case (a)
                    12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie = nv & m_chmask();
`ifdef CSR_VECTORED_EN
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
`else
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
`endif
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
            if (e_mret) begin
                m_mie_b = pre_mpie;
                m_mpie  = 1'b1;
            end
            m_flush = e_trap || e_mret;
            m_mip   = new_mip;
        end
    endtask

    task automatic t_rd(input logic [NUM_IRQ-1:0] ir, input logic [11:0] a);
        cyc(ir, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic t_wr(input logic [NUM_IRQ-1:0] ir, input logic [1:0] op,
                        input logic [11:0] a, input logic [31:0] d);
        cyc(ir, 1'b0, 32'h0, 1'b0, 1'b1, op, a, d, 1'b0, 1'b0);
    endtask

    task automatic t_ins(input logic [NUM_IRQ-1:0] ir, input logic v,
                         input logic [31:0] pc, input logic mr);
        cyc(ir, v, pc, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, mr, 1'b0);
    endtask

    logic [11:0] addrs [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    logic [31:0] exp_mtvec_101, exp_tpc_vec;

    initial begin
        logic [NUM_IRQ-1:0] cur_irq;
        logic [31:0]        tmp, wd, pc;
        logic [11:0]        a;
        logic               r, v, mr, re, we;
        logic [1:0]         op;

`ifdef CSR_VECTORED_EN
        exp_mtvec_101 = 32'h101;
        exp_tpc_vec   = 32'h144;
`else
        exp_mtvec_101 = 32'h100;
        exp_tpc_vec   = 32'h100;
`endif
        rst = 1'b1; irq = '0; instr_valid_de = 1'b0; pc_de = '0; csr_rf_rd = 1'b0;
        csr_rf_wr = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0; mret = 1'b0;

        cyc('0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1);
        cyc('0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1);

        // Reset values.
        for (int i = 0; i < 6; i++) begin
            t_rd('0, addrs[i]);
            chk("reset_csr_read", o_rdata, 32'h0);
        end
        chk("reset_trap", 32'(o_trap), 32'h0);
        chk("reset_trap_pc", o_tpc, 32'h0);
        chk("reset_epc", o_epc, 32'h0);

        // Timer interrupt, direct mode.
        t_wr('0, 2'b01, 12'h305, 32'h100);
        t_wr('0, 2'b01, 12'h304, 32'h80);
        t_wr('0, 2'b10, 12'h300, 32'h8);
        t_ins(4'b0001, 1'b1, 32'h40, 1'b0);
        chk("irq_rise_no_trap_yet", 32'(o_trap), 32'h0);
        t_ins(4'b0001, 1'b1, 32'h42, 1'b0);
        chk("timer_trap", 32'(o_trap), 32'h1);
        chk("timer_trap_pc", o_tpc, 32'h100);
        t_ins('0, 1'b0, 32'h0, 1'b0);
        t_rd('0, 12'h341);
        chk("timer_mepc", o_rdata, 32'h40);
        t_rd('0, 12'h342);
        chk("timer_mcause", o_rdata, 32'h8000_0007);
        t_rd('0, 12'h300);
        chk("timer_mstatus", o_rdata, 32'h80);
        chk("timer_epc", o_epc, 32'h40);
        t_ins('0, 1'b1, 32'h44, 1'b1);
        chk("mret_taken", 32'(o_mret), 32'h1);
        t_ins('0, 1'b0, 32'h0, 1'b0);
        t_rd('0, 12'h300);
        chk("mret_mstatus", o_rdata, 32'h88);

        // Priority between channels 1 and 3, then mret racing a pending irq.
        t_wr('0, 2'b01, 12'h304, 32'h0005_0000);
        t_ins(4'b1010, 1'b0, 32'h0, 1'b0);
        t_ins(4'b1010, 1'b1, 32'h80, 1'b0);
        chk("prio_trap", 32'(o_trap), 32'h1);
        t_ins(4'b1010, 1'b0, 32'h0, 1'b0);
        t_rd(4'b1010, 12'h342);
        chk("prio_cause16", o_rdata, 32'h8000_0010);
        t_wr(4'b1000, 2'b10, 12'h300, 32'h8);
        t_ins(4'b1000, 1'b1, 32'h84, 1'b1);
        chk("mret_wins_mret", 32'(o_mret), 32'h1);
        chk("mret_wins_trap", 32'(o_trap), 32'h0);
        t_ins(4'b1000, 1'b1, 32'h90, 1'b0);
        chk("flush_no_trap", 32'(o_trap), 32'h0);
        t_ins(4'b1000, 1'b1, 32'h94, 1'b0);
        chk("trap_after_flush", 32'(o_trap), 32'h1);
        t_ins('0, 1'b0, 32'h0, 1'b0);
        t_rd('0, 12'h342);
        chk("cause18", o_rdata, 32'h8000_0012);

        // Vectored dispatch (or direct when the option is absent).
        t_wr('0, 2'b01, 12'h305, 32'h101);
        t_wr('0, 2'b01, 12'h304, 32'h0002_0000);
        t_rd('0, 12'h305);
        chk("mtvec_mode_read", o_rdata, exp_mtvec_101);
        t_wr(4'b0100, 2'b10, 12'h300, 32'h8);
        t_ins(4'b0100, 1'b1, 32'hA0, 1'b0);
        chk("vec_trap", 32'(o_trap), 32'h1);
        chk("vec_trap_pc", o_tpc, exp_tpc_vec);
        t_ins(4'b0100, 1'b0, 32'h0, 1'b0);

        // csrrs / csrrc on mie.
        cyc(4'b0100, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 12'h304, 32'h80, 1'b0, 1'b0);
        chk("csrrs_old", o_rdata, 32'h0002_0000);
        cyc(4'b0100, 1'b0, 32'h0, 1'b1, 1'b1, 2'b11, 12'h304, 32'h80, 1'b0, 1'b0);
        chk("csrrc_old", o_rdata, 32'h0002_0080);
        t_rd(4'b0100, 12'h304);
        chk("csrrc_result", o_rdata, 32'h0002_0000);

        // CSR write in the trap cycle is dropped.
        t_wr(4'b0100, 2'b10, 12'h300, 32'h8);
        cyc(4'b0100, 1'b1, 32'hB0, 1'b0, 1'b1, 2'b01, 12'h305, 32'h200, 1'b0, 1'b0);
        chk("trap_with_write", 32'(o_trap), 32'h1);
        t_ins(4'b0100, 1'b0, 32'h0, 1'b0);
        t_rd(4'b0100, 12'h305);
        chk("write_discarded", o_rdata, exp_mtvec_101);

        // Reset during FLUSH.
        t_wr(4'b0100, 2'b10, 12'h300, 32'h8);
        t_ins(4'b0100, 1'b1, 32'hC0, 1'b0);
        chk("trap_before_reset", 32'(o_trap), 32'h1);
        cyc(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1);
        t_rd(4'b0100, 12'h305);
        chk("reset_in_flush_mtvec", o_rdata, 32'h0);
        t_rd(4'b0100, 12'h300);
        chk("reset_in_flush_mstatus", o_rdata, 32'h0);
        chk("reset_in_flush_epc", o_epc, 32'h0);

        // Randomized traffic against the model.
        cur_irq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tmp = $urandom;
                cur_irq = tmp[NUM_IRQ-1:0];
            end
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) != 0);
            mr = v && ($urandom_range(0, 15) == 0);
            re = $urandom_range(0, 1) == 1;
            we = !mr && ($urandom_range(0, 2) == 0);
            tmp = $urandom;
            op = tmp[1:0];
            if ($urandom_range(0, 7) != 0) a = addrs[$urandom_range(0, 5)];
            else a = tmp[13:2];
            case ($urandom_range(0, 3))
                0:       wd = $urandom;
                1:       wd = 32'h8;
                2:       wd = 32'h88;
                default: wd = m_chmask() | 32'h101;
            endcase
            pc = $urandom;
            cyc(cur_irq, v, pc, re, we, op, a, wd, mr, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap controller for the 3-stage core, generalised from a single timer interrupt to `NUM_IRQ` level-sensitive interrupt channels with fixed priority and optional vectored dispatch. It sits beside the decode/execute stage of the datapath. It owns mstatus/mie/mip/mtvec/mepc/mcause, services CSR read/write instructions and mret, and tells the datapath when and where to redirect the PC.

## Interface
- `NUM_IRQ`, 4: interrupt channels, 1..16; channel 0 is the machine timer.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `irq`  in  NUM_IRQ  level interrupt requests
- `instr_valid_de`  in  1  a real (non-bubble) instruction occupies decode/execute
- `pc_de`  in  32  PC of that instruction
- `csr_rf_rd` / `csr_rf_wr`  in  1 each  CSR read / write request from the controller
- `csr_op`  in  2  funct3[1:0]: 01 write, 10 set, 11 clear
- `csr_addr`  in  12  CSR address
- `csr_wdata`  in  32  rs1 value or zimm
- `mret`  in  1  mret in decode/execute
- `csr_rdata`  out  32  read data, combinational
- `trap_taken`  out  1  redirect to `trap_pc` at next edge
- `trap_pc`  out  32  handler address
- `mret_taken`  out  1  redirect to `mepc` at next edge
- `epc`  out  32  current mepc

## Operation
- Implemented CSRs: mstatus (MIE bit 3, MPIE bit 7, all other bits read 0), mie, mip (read-only), mtvec, mepc (bits[1:0] read 0), mcause. Other addresses read 0; writes to them are ignored.
- Channel mapping: irq[0] → mip/mie bit 7, cause 7; irq[k], k≥1 → bit 15+k, cause 15+k.
- mip is registered from `irq` every cycle. It is not writable.
- Priority: lowest channel index wins. Implemented as a combinational encoder over `mip & mie`.
- FSM states:
  - RUN: normal operation.
  - FLUSH: exactly one cycle after any trap or mret, while the pipeline refills. No trap is taken in FLUSH. CSR accesses are ignored in FLUSH.
  - Transitions: RUN→FLUSH on `trap_taken` or `mret_taken`; FLUSH→RUN unconditionally.
- Trap condition, all required in the same cycle: state RUN, `instr_valid_de`, !`mret`, MIE=1, and (mip & mie) ≠ 0.
- On trap, at the next edge:
  - mepc ← `pc_de` with bits[1:0] cleared.
  - mcause ← {1, cause}.
  - MPIE ← MIE; MIE ← 0.
  - The interrupted instruction's CSR write is discarded.
- mret (state RUN, `instr_valid_de`): `mret_taken`=1. At the next edge MIE ← MPIE and MPIE ← 1.
- CSR write value: write = wdata; set = old | wdata; clear = old & ~wdata. Writes use `csr_rf_wr` in state RUN with no trap that cycle.
- Reads return the pre-write value in the same cycle.

## Timing
- Reset values: all CSRs 0, state RUN, `trap_taken`=0, `mret_taken`=0, `csr_rdata`=0, `epc`=0, `trap_pc`=0.
- Interrupt latency:
  - `irq` rises in cycle n; mip is visible in cycle n+1.
  - `trap_taken` asserts combinationally in cycle n+1 if enabled and a valid instruction is present.
  - CSR updates occur at the n+2 edge.
- If `instr_valid_de`=0 (bubble), the trap is deferred until a valid instruction arrives.
- mret and a pending interrupt in the same cycle: mret wins. The interrupt is evaluated after FLUSH, i.e. two cycles later.
- `irq` dropping before the trap is taken: the trap is not taken (level semantics).
- `rst` asserted mid-FLUSH: returns to RUN and clears all state at that edge.

## Configuration
- `CSR_VECTORED_EN` defined:
  - mtvec[1:0] = 01 selects vectored mode.
  - `trap_pc` = {mtvec[31:2],2'b00} + 4·cause.
  - mtvec[1:0] = 00 selects direct mode.
- `CSR_VECTORED_EN` undefined: mtvec[1:0] is hardwired to 00 and reads 0. `trap_pc` is always {mtvec[31:2],2'b00}.

## Structure
- Package `csr_pkg` holds:
  - CSR address constants (0x300, 0x304, 0x305, 0x341, 0x342, 0x344).
  - Cause constants.
  - csr_op encodings.
  - The FSM state enum.
- One sub-module, `irq_prio_enc`, parametrised by `NUM_IRQ`. Outputs `any` and the winning `cause[4:0]`.

## Test plan
- Reset, then read all six CSRs → every value 0; `trap_taken`=0.
- Write mtvec=0x100, mie bit 7 and MIE=1; pulse irq[0] high with `pc_de`=0x40 → `trap_taken` one cycle after irq rises; `trap_pc`=0x100; mepc=0x40; mcause=0x80000007; MIE=0, MPIE=1.
- `NUM_IRQ`=4, irq[1] and irq[3] enabled and high together → cause 16 taken first. After mret and FLUSH, with irq[1] lowered → cause 18.
- `CSR_VECTORED_EN`, mtvec=0x101, irq[2] → `trap_pc`=0x100+4·17=0x144. Without the macro: mtvec reads 0x100 and `trap_pc`=0x100.
- mret asserted in the same cycle as an enabled pending irq → `mret_taken`=1 and `trap_taken`=0. `trap_taken`=1 two cycles later, provided the restored MIE=1.
- csrrs/csrrc on mie with wdata=0x80 → old value returned; bit 7 set then cleared. A CSR write in the trap cycle leaves the CSR unchanged.
